f1_reaction_timer: RTL and testbench
====================================

// Module: f1_reaction_timer
// PURPOSE
//  Consumer side of the F1 start-light bar. Watches the 8-bit thermometer light pattern and
//  the driver button. Measures reaction time in ms from lights-out (FF->00) to the button's
//  rising edge. Flags jump starts, timeouts and malformed patterns. Results feed the display/score path.
// PARAMETERS
//  CLK_PER_MS  48000  clk cycles per millisecond (>=2)
//  CNT_W       16     width of time_ms
//  MAX_MS      2000   timeout limit in ms (< 2**CNT_W)
// PORTS
//  clk           in   1      clock, all logic on posedge
//  rst           in   1      synchronous, active-high reset
//  lights        in   8      light bar pattern, synchronous to clk, thermometer code 00..FF
//  btn           in   1      driver button, synchronous to clk, level
//  lights_count  out  4      number of lit lights 0..8; 4'hF if pattern invalid
//  busy          out  1      1 in ARMED or TIMING
//  time_ms       out  CNT_W  measured reaction time, held until next race
//  time_valid    out  1      1-cycle pulse when a legal press is captured
//  jump_start    out  1      level: press before lights-out, held until next race
//  timeout       out  1      level: no press within MAX_MS, held until next race
//  pattern_err   out  1      1-cycle pulse on a non-thermometer pattern
// BEHAVIOUR
//  - All outputs are registered. On rst: state=IDLE, all outputs 0, prescaler=0, full_seen=0, btn_q=0.
//  - btn_rise = btn & ~btn_q, where btn_q is btn delayed by one cycle. A button already held
//    high gives no press; it must be released and pressed again.
//  - Valid patterns: 00,01,03,07,0F,1F,3F,7F,FF.
//  - lights_count follows lights with 1-cycle latency.
//  - An invalid pattern gives lights_count=F and pattern_err pulses for 1 cycle. In ARMED or
//    TIMING the FSM goes to IDLE, with time_ms=0 and no other flags.
//  - FSM states: IDLE, ARMED, TIMING, DONE, JUMP, TOUT.
//  - IDLE: lights==01 -> ARMED. btn is ignored.
//  - ARMED: full_seen is set when lights==FF.
//      - btn_rise -> JUMP: jump_start=1, time_ms=0.
//      - lights==00 with full_seen=1 -> TIMING: prescaler=0, time_ms=0.
//      - lights==00 with full_seen=0 (aborted sequence) -> IDLE, no flags.
//      - btn_rise in the same cycle as lights-out -> JUMP. Presses must strictly follow lights-out.
//  - TIMING: the prescaler counts 0..CLK_PER_MS-1. On wrap, time_ms increments.
//      - Result rule: time_ms = floor(N/CLK_PER_MS), where N = cycles between the sample of the
//        first 00 and the sample of btn_rise.
//      - btn_rise -> DONE: time_ms frozen, time_valid pulses in the same cycle time_ms updates.
//      - time_ms reaching MAX_MS -> TOUT: timeout=1, time_ms=MAX_MS (saturated, never wraps).
//      - btn_rise in the same cycle as reaching MAX_MS -> TOUT (timeout wins).
//      - lights becoming nonzero in TIMING -> IDLE, no flags.
//  - DONE/JUMP/TOUT: results are held and further btn activity is ignored.
//      - lights==01 -> ARMED. Same cycle: clear time_ms, jump_start, timeout, full_seen.
//  - full_seen clears on every entry to ARMED.
//  - rst at any point, including mid-TIMING, restores reset values on the next cycle.
//    Partial results are discarded.
// TESTING  (CLK_PER_MS=4, MAX_MS=10)
//  - Normal race: 01..FF, 3 cycles each, then 00; btn rises 13 cycles after lights-out
//    -> time_ms=3, time_valid=1 for 1 cycle, busy 1->0.
//  - Jump start: btn rises while lights=1F -> jump_start=1 and held, time_ms=0, no time_valid.
//    Then 01 -> jump_start=0, busy=1.
//  - Timeout: lights-out with no press for 40 cycles -> timeout=1, time_ms=10.
//    A later btn press changes nothing.
//  - Aborted: 01,03,00 -> IDLE, busy=0, all flags 0. Also: btn held high through lights-out
//    with no new rise -> TOUT.
//  - Bad pattern: lights=05 in ARMED -> pattern_err pulse, lights_count=F, busy=0.
//    Then 01 -> re-armed.
//  - Reset mid-TIMING at time_ms=2 -> all outputs 0 next cycle. A following full race
//    measures correctly from 0.

Source files
------------

// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: decodes the thermometer light bar, times the driver's
// press from lights-out in milliseconds and flags jump starts, timeouts and bad patterns.
module f1_reaction_timer #(
  parameter int CLK_PER_MS = 48000,
  parameter int CNT_W      = 16,
  parameter int MAX_MS     = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lights,
  input  logic             btn,
  output logic [3:0]       lights_count,
  output logic             busy,
  output logic [CNT_W-1:0] time_ms,
  output logic             time_valid,
  output logic             jump_start,
  output logic             timeout,
  output logic             pattern_err
);

  localparam int                PRE_W    = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [CNT_W-1:0]  TIME_MAX = CNT_W'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_JUMP   = 3'd4,
    S_TOUT   = 3'd5
  } state_t;

  // Number of lit lights for a legal thermometer pattern, 4'hF for anything else.
  function automatic logic [3:0] therm_count(input logic [7:0] pat);
    logic [3:0] cnt;
    case (pat)
      8'h00:   cnt = 4'd0;
      8'h01:   cnt = 4'd1;
      8'h03:   cnt = 4'd2;
      8'h07:   cnt = 4'd3;
      8'h0F:   cnt = 4'd4;
      8'h1F:   cnt = 4'd5;
      8'h3F:   cnt = 4'd6;
      8'h7F:   cnt = 4'd7;
      8'hFF:   cnt = 4'd8;
      default: cnt = 4'hF;
    endcase
    return cnt;
  endfunction

  state_t           state_r, state_s;
  logic [PRE_W-1:0] pre_r, pre_s;
  logic             full_seen_r, full_seen_s;
  logic             btn_q_r;
  logic [CNT_W-1:0] time_ms_s;
  logic             valid_s, jump_s, tout_s, busy_s;
  logic [3:0]       count_s;
  logic             bad_s, btn_rise_s, lights_zero_s, lights_one_s, lights_full_s;
  logic             wrap_s;
  logic [PRE_W-1:0] pre_inc_s;
  logic [CNT_W-1:0] time_inc_s;

  assign count_s       = therm_count(lights);
  assign bad_s         = (count_s == 4'hF);
  assign btn_rise_s    = btn & ~btn_q_r;
  assign lights_zero_s = (lights == 8'h00);
  assign lights_one_s  = (lights == 8'h01);
  assign lights_full_s = (lights == 8'hFF);
  // The press is credited with the cycle it lands in, so the pending wrap is folded in.
  assign wrap_s        = (pre_r == PRE_LAST);
  assign pre_inc_s     = wrap_s ? {PRE_W{1'b0}} : (pre_r + PRE_W'(1));
  assign time_inc_s    = time_ms + {{(CNT_W-1){1'b0}}, wrap_s};

  // Next-state and next-output logic for the race FSM.
  always_comb begin
    state_s     = state_r;
    pre_s       = pre_r;
    full_seen_s = full_seen_r;
    time_ms_s   = time_ms;
    jump_s      = jump_start;
    tout_s      = timeout;
    valid_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (lights_one_s) begin
          state_s     = S_ARMED;
          full_seen_s = 1'b0;
          time_ms_s   = {CNT_W{1'b0}};
          jump_s      = 1'b0;
          tout_s      = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (bad_s) begin
          state_s   = S_IDLE;
          time_ms_s = {CNT_W{1'b0}};
        end else if (btn_rise_s) begin
          state_s   = S_JUMP;
          jump_s    = 1'b1;
          time_ms_s = {CNT_W{1'b0}};
        end else if (lights_zero_s) begin
          if (full_seen_r) begin
            state_s   = S_TIMING;
            pre_s     = {PRE_W{1'b0}};
            time_ms_s = {CNT_W{1'b0}};
          end else begin
            state_s = S_IDLE;
          end
        end else if (lights_full_s) begin
          full_seen_s = 1'b1;
        end else begin
          full_seen_s = full_seen_r;
        end
      end
      S_TIMING: begin
        if (!lights_zero_s) begin
          state_s   = S_IDLE;
          pre_s     = {PRE_W{1'b0}};
          time_ms_s = {CNT_W{1'b0}};
        end else if (wrap_s && (time_inc_s >= TIME_MAX)) begin
          state_s   = S_TOUT;
          tout_s    = 1'b1;
          time_ms_s = TIME_MAX;
        end else if (btn_rise_s) begin
          state_s   = S_DONE;
          time_ms_s = time_inc_s;
          valid_s   = 1'b1;
        end else begin
          pre_s     = pre_inc_s;
          time_ms_s = time_inc_s;
        end
      end
      S_DONE, S_JUMP, S_TOUT: begin
        if (lights_one_s) begin
          state_s     = S_ARMED;
          full_seen_s = 1'b0;
          time_ms_s   = {CNT_W{1'b0}};
          jump_s      = 1'b0;
          tout_s      = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s     = S_IDLE;
        pre_s       = {PRE_W{1'b0}};
        full_seen_s = 1'b0;
        time_ms_s   = {CNT_W{1'b0}};
        jump_s      = 1'b0;
        tout_s      = 1'b0;
      end
    endcase
    busy_s = (state_s == S_ARMED) || (state_s == S_TIMING);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pre_r        <= {PRE_W{1'b0}};
      full_seen_r  <= 1'b0;
      btn_q_r      <= 1'b0;
      lights_count <= 4'd0;
      busy         <= 1'b0;
      time_ms      <= {CNT_W{1'b0}};
      time_valid   <= 1'b0;
      jump_start   <= 1'b0;
      timeout      <= 1'b0;
      pattern_err  <= 1'b0;
    end else begin
      state_r      <= state_s;
      pre_r        <= pre_s;
      full_seen_r  <= full_seen_s;
      btn_q_r      <= btn;
      lights_count <= count_s;
      busy         <= busy_s;
      time_ms      <= time_ms_s;
      time_valid   <= valid_s;
      jump_start   <= jump_s;
      timeout      <= tout_s;
      pattern_err  <= bad_s;
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer at CLK_PER_MS=4, MAX_MS=10: a vector table for
// arming/jump/abort/bad-pattern behaviour plus hand-written races for timing corners.
module tb_f1_reaction_timer;

  localparam int CPM = 4;
  localparam int MAXMS = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lights = 8'h00;
  logic        btn = 1'b0;
  logic [3:0]  lights_count;
  logic        busy;
  logic [15:0] time_ms;
  logic        time_valid, jump_start, timeout, pattern_err;

  int n_cmp = 0;
  int n_fail = 0;

  f1_reaction_timer #(.CLK_PER_MS(CPM), .CNT_W(16), .MAX_MS(MAXMS)) dut (
    .clk(clk), .rst(rst), .lights(lights), .btn(btn),
    .lights_count(lights_count), .busy(busy), .time_ms(time_ms),
    .time_valid(time_valid), .jump_start(jump_start), .timeout(timeout),
    .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  l;
    logic        b;
    logic [3:0]  c;
    logic        bz;
    logic [15:0] t;
    logic        v, j, o, p;
  } vec_t;

  vec_t tbl [17];

  task automatic step(input logic [7:0] l, input logic b);
    lights = l;
    btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] c, input logic bz,
                            input logic [15:0] t, input logic v, input logic j,
                            input logic o, input logic p);
    n_cmp++;
    if (lights_count !== c || busy !== bz || time_ms !== t || time_valid !== v ||
        jump_start !== j || timeout !== o || pattern_err !== p) begin
      n_fail++;
      $display("FAIL %s: got cnt=%h busy=%b time=%0d valid=%b jump=%b tout=%b perr=%b; want cnt=%h busy=%b time=%0d valid=%b jump=%b tout=%b perr=%b",
               nm, lights_count, busy, time_ms, time_valid, jump_start, timeout, pattern_err,
               c, bz, t, v, j, o, p);
    end
  endtask

  // Light the bar 01..FF, three cycles per level, checking the armed state per level.
  task automatic run_up(input logic b);
    logic [7:0] pat;
    for (int lvl = 1; lvl <= 8; lvl++) begin
      pat = 8'((16'd1 << lvl) - 16'd1);
      for (int r = 0; r < 3; r++) step(pat, b);
      expect_out("armed_level", 4'(lvl), 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic lights_out(input logic b);
    step(8'h00, b);
    expect_out("lights_out", 4'd0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // k cycles after the first 00 sample the elapsed time is floor(k/CPM).
  task automatic timing_run(input int kmax, input logic b);
    for (int k = 1; k <= kmax; k++) begin
      step(8'h00, b);
      expect_out("timing", 4'd0, 1'b1, 16'(k / CPM), 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    //           lights  btn   cnt   busy  time    valid jump  tout  perr
    tbl[0]  = '{8'h01, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h03, 1'b0, 4'd2, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h07, 1'b0, 4'd3, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h0F, 1'b0, 4'd4, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h1F, 1'b0, 4'd5, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h1F, 1'b1, 4'd5, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{8'h3F, 1'b0, 4'd6, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{8'h01, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h03, 1'b0, 4'd2, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{8'h05, 1'b0, 4'hF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{8'h03, 1'b0, 4'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{8'h01, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{8'h81, 1'b0, 4'hF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{8'h00, 1'b0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    expect_out("reset", 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].l, tbl[i].b);
      expect_out($sformatf("vec%0d", i), tbl[i].c, tbl[i].bz, tbl[i].t,
                 tbl[i].v, tbl[i].j, tbl[i].o, tbl[i].p);
    end

    // Normal race: press sampled 13 cycles after lights-out -> 3 ms.
    run_up(1'b0);
    lights_out(1'b0);
    timing_run(12, 1'b0);
    step(8'h00, 1'b1);
    expect_out("race_capture", 4'd0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1);
    expect_out("race_pulse_end", 4'd0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    expect_out("race_hold", 4'd0, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout with no press, then a late press is ignored.
    run_up(1'b0);
    lights_out(1'b0);
    timing_run(39, 1'b0);
    step(8'h00, 1'b0);
    expect_out("timeout", 4'd0, 1'b0, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b1);
    expect_out("timeout_late_press", 4'd0, 1'b0, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0);

    // Button held high through the whole sequence never produces a press.
    run_up(1'b1);
    lights_out(1'b1);
    timing_run(39, 1'b1);
    step(8'h00, 1'b1);
    expect_out("held_btn_timeout", 4'd0, 1'b0, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0);

    // Press in the very cycle the limit is reached: timeout wins.
    run_up(1'b0);
    lights_out(1'b0);
    timing_run(39, 1'b0);
    step(8'h00, 1'b1);
    expect_out("tout_wins", 4'd0, 1'b0, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0);

    // Press in the same cycle as lights-out is a jump start.
    run_up(1'b0);
    step(8'h00, 1'b1);
    expect_out("jump_at_out", 4'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Lights come back during timing: abort to idle, then re-arm.
    run_up(1'b0);
    lights_out(1'b0);
    timing_run(2, 1'b0);
    step(8'h01, 1'b0);
    expect_out("timing_abort", 4'd1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h01, 1'b0);
    expect_out("rearm", 4'd1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-timing, then a clean race measures from zero.
    run_up(1'b0);
    lights_out(1'b0);
    timing_run(10, 1'b0);
    rst = 1'b1;
    step(8'h00, 1'b0);
    expect_out("reset_mid", 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    run_up(1'b0);
    lights_out(1'b0);
    timing_run(6, 1'b0);
    step(8'h00, 1'b1);
    expect_out("post_reset_race", 4'd0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
